conf_mem_n: RTL and testbench

- Parametrised configuration/status register bank for video IPs. Generalises the fixed 4-register config memory to NUM_OF_REG entries.
- Adds per-register read-only status sampling and sticky write-1-to-clear status.
- Adds shadow/active double buffering, so configuration changes take effect only at a frame boundary (frm_sync).
- Sits between the host register bus and the video datapath.

---
 rtl/conf_mem_pkg.sv | 25 ++
 rtl/conf_reg_slot.sv | 69 ++++++
 rtl/conf_mem_n.sv | 100 ++++++++++
 tb/tb_conf_mem_n.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/conf_mem_pkg.sv
// Shared definitions for the conf_mem_n register bank: slot kinds and flat-bus helpers.
package conf_mem_pkg;

   // Behaviour class of a single register slot
   typedef enum logic [1:0] {
      KIND_RW_SYNC   = 2'd0,  // host-writable, active copy follows shadow at frame sync
      KIND_RW_IMM    = 2'd1,  // host-writable, active copy follows the write at once
      KIND_RO        = 2'd2,  // status, resampled from sts_in every cycle
      KIND_RO_STICKY = 2'd3   // status, bits set by sts_in and cleared by host write-1
   } slot_kind_e;

   // Map the per-slot parameter mask bits onto a slot kind
   function automatic slot_kind_e slot_kind(input logic dir, input logic sticky, input logic imm);
      if (dir) begin
         return sticky ? KIND_RO_STICKY : KIND_RO;
      end
      return imm ? KIND_RW_IMM : KIND_RW_SYNC;
   endfunction

   // Bit offset of slot idx inside a flat bus of dw-bit slots
   function automatic int unsigned slot_lsb(input int unsigned idx, input int unsigned dw);
      return idx * dw;
   endfunction

endpackage

// File: rtl/conf_reg_slot.sv
// One register slot of conf_mem_n; its behaviour is selected by KIND.
module conf_reg_slot
   import conf_mem_pkg::*;
#(
   parameter int unsigned   DW   = 16,
   parameter slot_kind_e    KIND = KIND_RW_SYNC,
   parameter logic [DW-1:0] DEF  = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_i,    // host write strobe already qualified by address hit
   input  logic [DW-1:0] wdt_i,
   input  logic          sync_i,  // frame boundary
   input  logic [DW-1:0] sts_i,
   output logic [DW-1:0] rd_o,    // host-visible value (shadow or status)
   output logic [DW-1:0] cfg_o,   // datapath-visible value (active or status)
   output logic          diff_o   // frame-synced shadow differs from active
);

   logic [DW-1:0] shadow_q, shadow_d;
   logic [DW-1:0] active_q, active_d;

   // Next-state selection per slot kind; for status kinds both copies carry the status value
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      case (KIND)
         KIND_RW_SYNC: begin
            if (wr_i)   shadow_d = wdt_i;
            // commits the pre-write shadow when a write lands on the sync cycle
            if (sync_i) active_d = shadow_q;
         end
         KIND_RW_IMM: begin
            if (wr_i) begin
               shadow_d = wdt_i;
               active_d = wdt_i;
            end else if (sync_i) begin
               active_d = shadow_q;
            end
         end
         KIND_RO: begin
            shadow_d = sts_i;
            active_d = sts_i;
         end
         KIND_RO_STICKY: begin
            // OR-ing sts_i last makes a set win over a same-cycle clear
            shadow_d = (shadow_q & ~(wr_i ? wdt_i : '0)) | sts_i;
            active_d = shadow_d;
         end
         default: ;
      endcase
   end

   // Slot storage with synchronous reset to the default value
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= DEF;
         active_q <= DEF;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign rd_o   = shadow_q;
   assign cfg_o  = active_q;
   assign diff_o = (KIND == KIND_RW_SYNC) && (shadow_q != active_q);

endmodule

// File: rtl/conf_mem_n.sv
// Parametrised config/status register bank with frame-synchronised double buffering.
module conf_mem_n
   import conf_mem_pkg::*;
#(
   parameter int unsigned                       DW_MA      = 8,
   parameter int unsigned                       DW_MD      = 16,
   parameter int unsigned                       NUM_OF_REG = 8,
   parameter logic [NUM_OF_REG*DW_MD-1:0]       DEF_M      = '0,
   parameter logic [NUM_OF_REG-1:0]             DIR_M      = '0,
   parameter logic [NUM_OF_REG-1:0]             STICKY_M   = '0,
   parameter logic [NUM_OF_REG-1:0]             IMM_M      = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DW_MA-1:0]            adr,
   input  logic [DW_MD-1:0]            wdt,
   input  logic                        wen,
   input  logic                        ren,
   output logic [DW_MD-1:0]            rdt,
   output logic                        rvld,
   output logic                        err,
   input  logic                        frm_sync,
   input  logic [NUM_OF_REG*DW_MD-1:0] sts_in,
   output logic [NUM_OF_REG*DW_MD-1:0] cfg_out,
   output logic                        pend
);

   logic [31:0]      adr_ext;
   logic             in_range;
   logic [DW_MD-1:0] rd_slot [NUM_OF_REG];
   logic [NUM_OF_REG-1:0] diff;
   logic [DW_MD-1:0] rd_mux;

   logic [DW_MD-1:0] rdt_q, rdt_d;
   logic             rvld_q, rvld_d;
   logic             err_q, err_d;
   logic             pend_q, pend_d;

   assign adr_ext  = 32'(adr);
   assign in_range = adr_ext < 32'(NUM_OF_REG);

   for (genvar gi = 0; gi < NUM_OF_REG; gi++) begin : g_slot
      logic hit;
      assign hit = wen && in_range && (adr_ext == 32'(gi));

      conf_reg_slot #(
         .DW   (DW_MD),
         .KIND (slot_kind(DIR_M[gi], STICKY_M[gi], IMM_M[gi])),
         .DEF  (DEF_M[slot_lsb(gi, DW_MD) +: DW_MD])
      ) u_slot (
         .clk    (clk),
         .rst    (rst),
         .wr_i   (hit),
         .wdt_i  (wdt),
         .sync_i (frm_sync),
         .sts_i  (sts_in[slot_lsb(gi, DW_MD) +: DW_MD]),
         .rd_o   (rd_slot[gi]),
         .cfg_o  (cfg_out[slot_lsb(gi, DW_MD) +: DW_MD]),
         .diff_o (diff[gi])
      );
   end

   // Read mux over slot values as they stand before this edge
   always_comb begin
      rd_mux = '0;
      for (int unsigned i = 0; i < NUM_OF_REG; i++) begin
         if (adr_ext == i) rd_mux = rd_slot[i];
      end
   end

   // Host response and pending-flag next state
   always_comb begin
      rvld_d = ren;
      err_d  = (ren || wen) && !in_range;
      rdt_d  = rdt_q;
      if (ren) rdt_d = in_range ? rd_mux : '0;
      pend_d = |diff;
   end

   // Host response and pending-flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rdt_q  <= '0;
         rvld_q <= 1'b0;
         err_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         rdt_q  <= rdt_d;
         rvld_q <= rvld_d;
         err_q  <= err_d;
         pend_q <= pend_d;
      end
   end

   assign rdt  = rdt_q;
   assign rvld = rvld_q;
   assign err  = err_q;
   assign pend = pend_q;

endmodule

// File: tb/tb_conf_mem_n.sv
// Directed table-driven bench for conf_mem_n.
module tb_conf_mem_n;

   localparam int unsigned DW_MA = 8;
   localparam int unsigned DW_MD = 16;
   localparam int unsigned NREG  = 8;
   // slot0 00A5, slot1 0011, slot2 0022 (IMM), slot3 0033, slot4 RO, slot5 RO sticky, slot6 RW, slot7 RO
   localparam logic [NREG*DW_MD-1:0] DEF = {16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                            16'h0033, 16'h0022, 16'h0011, 16'h00A5};
   localparam logic [NREG-1:0] DIR = 8'b1011_0000;
   localparam logic [NREG-1:0] STK = 8'b0010_0000;
   localparam logic [NREG-1:0] IMM = 8'b0000_0100;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [DW_MA-1:0]       adr;
   logic [DW_MD-1:0]       wdt;
   logic                   wen, ren, frm_sync;
   logic [DW_MD-1:0]       rdt;
   logic                   rvld, err, pend;
   logic [NREG*DW_MD-1:0]  sts_in;
   logic [NREG*DW_MD-1:0]  cfg_out;

   int checks = 0;
   int errors = 0;

   conf_mem_n #(
      .DW_MA(DW_MA), .DW_MD(DW_MD), .NUM_OF_REG(NREG),
      .DEF_M(DEF), .DIR_M(DIR), .STICKY_M(STK), .IMM_M(IMM)
   ) dut (
      .clk(clk), .rst(rst), .adr(adr), .wdt(wdt), .wen(wen), .ren(ren),
      .rdt(rdt), .rvld(rvld), .err(err), .frm_sync(frm_sync),
      .sts_in(sts_in), .cfg_out(cfg_out), .pend(pend)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wen, ren, sync;
      logic [7:0]  adr;
      logic [15:0] wdt, s4, s5;
      logic        xrvld;
      logic [15:0] xrdt;
      logic        xerr, xpend;
      int          cs;
      logic [15:0] xcfg;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic w, logic r, logic [7:0] a, logic [15:0] d, logic s,
                               logic [15:0] s4, logic [15:0] s5, logic xv, logic [15:0] xd,
                               logic xe, logic xp, int cs, logic [15:0] xc);
      vec_t v;
      v.wen = w; v.ren = r; v.adr = a; v.wdt = d; v.sync = s; v.s4 = s4; v.s5 = s5;
      v.xrvld = xv; v.xrdt = xd; v.xerr = xe; v.xpend = xp; v.cs = cs; v.xcfg = xc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic r, input logic [7:0] a, input logic [15:0] d,
                        input logic s, input logic [15:0] s4, input logic [15:0] s5);
      wen = w; ren = r; adr = a; wdt = d; frm_sync = s;
      sts_in = '0;
      sts_in[4*DW_MD +: DW_MD] = s4;
      sts_in[5*DW_MD +: DW_MD] = s5;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] slot(input int i);
      return cfg_out[i*DW_MD +: DW_MD];
   endfunction

   initial begin
      rst = 1'b1;
      wen = 0; ren = 0; adr = '0; wdt = '0; frm_sync = 0; sts_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      //                 wen ren adr    wdt       sync s4        s5        rvld rdt       err pend slot cfg
      vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h00A5));
      vecs.push_back(mk(0, 1, 8'h00, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h00A5, 0, 0, 0, 16'h00A5));
      vecs.push_back(mk(1, 0, 8'h01, 16'h1234, 0, 16'h0000, 16'h0000, 0, 16'h00A5, 0, 0, 1, 16'h0011));
      for (int k = 0; k < 9; k++)
         vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h00A5, 0, 1, 1, 16'h0011));
      vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 16'h0000, 16'h0000, 0, 16'h00A5, 0, 1, 1, 16'h1234));
      vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h00A5, 0, 0, 1, 16'h1234));
      vecs.push_back(mk(0, 1, 8'h01, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0, 1, 16'h1234));
      // immediate slot written on sync cycle, then frame-synced slot written on sync cycle
      vecs.push_back(mk(1, 0, 8'h02, 16'h00FF, 1, 16'h0000, 16'h0000, 0, 16'h1234, 0, 0, 2, 16'h00FF));
      vecs.push_back(mk(1, 0, 8'h03, 16'h4444, 1, 16'h0000, 16'h0000, 0, 16'h1234, 0, 0, 3, 16'h0033));
      vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 1, 3, 16'h0033));
      vecs.push_back(mk(1, 1, 8'h03, 16'h5555, 0, 16'h0000, 16'h0000, 1, 16'h4444, 0, 1, 3, 16'h0033));
      vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 16'h0000, 16'h0000, 0, 16'h4444, 0, 1, 3, 16'h5555));
      vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h4444, 0, 0, 3, 16'h5555));
      // sticky status slot
      vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 16'h0000, 16'h0005, 0, 16'h4444, 0, 0, 5, 16'h0005));
      vecs.push_back(mk(0, 1, 8'h05, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0005, 0, 0, 5, 16'h0005));
      vecs.push_back(mk(1, 0, 8'h05, 16'h0001, 0, 16'h0000, 16'h0001, 0, 16'h0005, 0, 0, 5, 16'h0005));
      vecs.push_back(mk(1, 0, 8'h05, 16'h0004, 0, 16'h0000, 16'h0000, 0, 16'h0005, 0, 0, 5, 16'h0001));
      vecs.push_back(mk(0, 1, 8'h05, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0001, 0, 0, 5, 16'h0001));
      // plain status slot: write ignored, one cycle sampling latency
      vecs.push_back(mk(1, 0, 8'h04, 16'hFFFF, 0, 16'hABCD, 16'h0000, 0, 16'h0001, 0, 0, 4, 16'hABCD));
      vecs.push_back(mk(0, 1, 8'h04, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'hABCD, 0, 0, 4, 16'h0000));
      // out of range: adr 9 aliases slot1 in the low bits, adr 8 is the first invalid address
      vecs.push_back(mk(1, 0, 8'h09, 16'h7777, 0, 16'h0000, 16'h0000, 0, 16'hABCD, 1, 0, 1, 16'h1234));
      vecs.push_back(mk(0, 1, 8'h09, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 0, 1, 16'h1234));
      vecs.push_back(mk(0, 1, 8'h01, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0, 1, 16'h1234));
      vecs.push_back(mk(0, 1, 8'h08, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 0, 0, 16'h00A5));

      foreach (vecs[i]) begin
         drive(vecs[i].wen, vecs[i].ren, vecs[i].adr, vecs[i].wdt, vecs[i].sync, vecs[i].s4, vecs[i].s5);
         chk($sformatf("v%0d rvld", i), 128'(rvld), 128'(vecs[i].xrvld));
         chk($sformatf("v%0d rdt", i),  128'(rdt),  128'(vecs[i].xrdt));
         chk($sformatf("v%0d err", i),  128'(err),  128'(vecs[i].xerr));
         chk($sformatf("v%0d pend", i), 128'(pend), 128'(vecs[i].xpend));
         chk($sformatf("v%0d cfg%0d", i, vecs[i].cs), 128'(slot(vecs[i].cs)), 128'(vecs[i].xcfg));
      end

      // reset mid-frame with pending shadow writes and a write in the reset cycle
      drive(1, 0, 8'h00, 16'hDEAD, 0, 16'h0000, 16'h0000);
      drive(1, 0, 8'h01, 16'hBEEF, 0, 16'h0000, 16'h0000);
      drive(0, 0, 8'h00, 16'h0000, 0, 16'h0000, 16'h0000);
      chk("pre-reset pend", 128'(pend), 128'(1'b1));
      chk("pre-reset cfg0", 128'(slot(0)), 128'(16'h00A5));
      rst = 1'b1;
      drive(1, 1, 8'h06, 16'h6666, 0, 16'h0000, 16'h0000);
      rst = 1'b0;
      chk("reset pend", 128'(pend), 128'(1'b0));
      chk("reset rvld", 128'(rvld), 128'(1'b0));
      chk("reset rdt", 128'(rdt), 128'(16'h0000));
      chk("reset cfg", cfg_out, DEF);
      drive(0, 0, 8'h00, 16'h0000, 1, 16'h0000, 16'h0000);
      chk("post-sync cfg", cfg_out, DEF);
      drive(0, 0, 8'h00, 16'h0000, 0, 16'h0000, 16'h0000);
      chk("post-sync pend", 128'(pend), 128'(1'b0));
      drive(0, 1, 8'h00, 16'h0000, 0, 16'h0000, 16'h0000);
      chk("post-reset rd0", 128'(rdt), 128'(16'h00A5));
      drive(0, 1, 8'h06, 16'h0000, 0, 16'h0000, 16'h0000);
      chk("post-reset rd6", 128'(rdt), 128'(16'h0000));
      chk("post-reset rvld", 128'(rvld), 128'(1'b1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
